// File: rtl/misao_core.sv
// MISA-O nibble-serial accumulator CPU: byte fetch, two nibbles executed low first.
// Optional AND/OR/XOR/NOT are built only when MISAO_LOGIC_EN is defined.
module misao_core (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_enable_read,
  output logic        mem_enable_write,
  input  logic [7:0]  mem_data_in,
  output logic [14:0] mem_addr,
  output logic        mem_rw,
  output logic [7:0]  mem_data_out,
  output logic [15:0] test_data,
  output logic        test_carry
);

  typedef enum logic [1:0] {FETCH, EXLO, EXHI, MEM} state_t;

  state_t      r_state, w_nextState;
  logic [14:0] r_pc;
  logic [15:0] r_acc, r_rs0, r_rs1, r_ra0, r_ra1;
  logic        r_c;
  logic [7:0]  r_cfg, r_ir;
  logic        r_xop;
  logic [2:0]  r_opCnt;
  logic [1:0]  r_opIdx;
  logic        r_opCfg, r_opWide;
  logic        r_memWr, r_memRet;

  logic [3:0]  w_nib;
  logic        w_exec, w_opnd, w_prim, w_ext, w_wide, w_jmp, w_memOp;
  logic [16:0] w_full;
  logic [4:0]  w_low;
  logic        w_aluOp, w_aluCarry, w_aluC;
  logic [15:0] w_aluRes;
  logic        w_unused;

  assign w_wide   = r_cfg[1];
  assign w_exec   = (r_state == EXLO) || (r_state == EXHI);
  assign w_nib    = (r_state == EXHI) ? r_ir[7:4] : r_ir[3:0];
  assign w_opnd   = (r_opCnt != 3'd0);
  assign w_prim   = w_exec && !w_opnd && !r_xop;
  assign w_ext    = w_exec && !w_opnd && r_xop;
  assign w_jmp    = w_prim && (w_nib == 4'hD);
  assign w_memOp  = w_prim && ((w_nib == 4'hB) || (w_nib == 4'hC));
  assign w_unused = ^{r_cfg[7:2], r_cfg[0]};

  // Both widths are computed; UL keeps ACC[15:4] and takes carry from bit 3.
  always_comb begin
    w_full     = 17'd0;
    w_low      = 5'd0;
    w_aluOp    = 1'b0;
    w_aluCarry = 1'b0;
    case (w_nib)
      4'h4: begin
        w_full     = {1'b0, r_acc} + {1'b0, r_rs0};
        w_low      = {1'b0, r_acc[3:0]} + {1'b0, r_rs0[3:0]};
        w_aluOp    = 1'b1;
        w_aluCarry = 1'b1;
      end
      4'h5: begin
        w_full     = {1'b0, r_acc} - {1'b0, r_rs0};
        w_low      = {1'b0, r_acc[3:0]} - {1'b0, r_rs0[3:0]};
        w_aluOp    = 1'b1;
        w_aluCarry = 1'b1;
      end
      4'h9: begin
        w_full     = {1'b0, r_acc} + 17'd1;
        w_low      = {1'b0, r_acc[3:0]} + 5'd1;
        w_aluOp    = 1'b1;
        w_aluCarry = 1'b1;
      end
`ifdef MISAO_LOGIC_EN
      4'h6: begin
        w_full  = {1'b0, r_acc & r_rs0};
        w_low   = {1'b0, r_acc[3:0] & r_rs0[3:0]};
        w_aluOp = 1'b1;
      end
      4'h7: begin
        w_full  = {1'b0, r_acc | r_rs0};
        w_low   = {1'b0, r_acc[3:0] | r_rs0[3:0]};
        w_aluOp = 1'b1;
      end
      4'h8: begin
        w_full  = {1'b0, r_acc ^ r_rs0};
        w_low   = {1'b0, r_acc[3:0] ^ r_rs0[3:0]};
        w_aluOp = 1'b1;
      end
      4'hA: begin
        w_full  = {1'b0, ~r_acc};
        w_low   = {1'b0, ~r_acc[3:0]};
        w_aluOp = 1'b1;
      end
`endif
      default: ;
    endcase
    w_aluRes = w_wide ? w_full[15:0] : {r_acc[15:4], w_low[3:0]};
    w_aluC   = w_wide ? w_full[16] : w_low[4];
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FETCH:   w_nextState = EXLO;
      EXLO:    w_nextState = w_jmp ? FETCH : (w_memOp ? MEM : EXHI);
      EXHI:    w_nextState = w_memOp ? MEM : FETCH;
      MEM:     w_nextState = r_memRet ? EXHI : FETCH;
      default: w_nextState = FETCH;
    endcase
  end

  always_comb begin
    mem_enable_read  = 1'b0;
    mem_enable_write = 1'b0;
    mem_rw           = 1'b0;
    mem_addr         = 15'd0;
    mem_data_out     = 8'd0;
    if (!rst) begin
      mem_enable_read  = (r_state == FETCH) || ((r_state == MEM) && !r_memWr);
      mem_enable_write = (r_state == MEM) && r_memWr;
      mem_rw           = (r_state == MEM) && r_memWr;
      mem_addr         = (r_state == MEM) ? r_ra0[14:0] : r_pc;
      mem_data_out     = r_acc[7:0];
    end
  end

  assign test_data  = r_acc;
  assign test_carry = r_c;

  always_ff @(posedge clk) begin
    if (rst) r_state <= FETCH;
    else     r_state <= w_nextState;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc     <= 15'd0;
      r_acc    <= 16'd0;
      r_c      <= 1'b0;
      r_rs0    <= 16'd0;
      r_rs1    <= 16'd0;
      r_ra0    <= 16'd0;
      r_ra1    <= 16'd0;
      r_cfg    <= 8'd0;
      r_ir     <= 8'd0;
      r_xop    <= 1'b0;
      r_opCnt  <= 3'd0;
      r_opIdx  <= 2'd0;
      r_opCfg  <= 1'b0;
      r_opWide <= 1'b0;
      r_memWr  <= 1'b0;
      r_memRet <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          r_ir <= mem_data_in;
          r_pc <= r_pc + 15'd1;
        end
        MEM: begin
          if (!r_memWr) r_acc[7:0] <= mem_data_in;
        end
        default: begin
          // Pending operand nibbles take priority over opcode decoding.
          if (w_opnd) begin
            r_opCnt <= r_opCnt - 3'd1;
            r_opIdx <= r_opIdx + 2'd1;
            if (r_opCfg) begin
              if (r_opIdx[0]) r_cfg[7:4] <= w_nib;
              else            r_cfg[3:0] <= w_nib;
            end else if (r_opWide) begin
              case (r_opIdx)
                2'd0: r_acc[3:0]   <= w_nib;
                2'd1: r_acc[7:4]   <= w_nib;
                2'd2: r_acc[11:8]  <= w_nib;
                2'd3: r_acc[15:12] <= w_nib;
                default: ;
              endcase
            end else begin
              r_acc[3:0] <= w_nib;
            end
          end else if (w_ext) begin
            r_xop <= 1'b0;
            case (w_nib)
              4'h0: begin
                r_opCnt <= 3'd2;
                r_opIdx <= 2'd0;
                r_opCfg <= 1'b1;
              end
              4'h1: begin
                r_acc <= r_ra0;
                r_ra0 <= r_acc;
              end
              4'h2: begin
                r_ra0 <= r_ra1;
                r_ra1 <= r_ra0;
              end
              4'h3: r_rs0 <= {1'b0, r_rs0[15:1]};
              4'h4: r_c <= 1'b0;
              4'h5: r_c <= 1'b1;
              default: ;
            endcase
          end else if (w_prim) begin
            if (w_aluOp) begin
              r_acc <= w_aluRes;
              if (w_aluCarry) r_c <= w_aluC;
            end
            case (w_nib)
              4'h1: begin
                r_opCnt  <= w_wide ? 3'd4 : 3'd1;
                r_opIdx  <= 2'd0;
                r_opCfg  <= 1'b0;
                r_opWide <= w_wide;
              end
              4'h2: begin
                r_acc <= r_rs0;
                r_rs0 <= r_acc;
              end
              4'h3: begin
                r_rs0 <= r_rs1;
                r_rs1 <= r_rs0;
              end
              4'hB, 4'hC: begin
                r_memWr  <= (w_nib == 4'hC);
                r_memRet <= (r_state == EXLO);
              end
              4'hD: r_pc <= r_ra0[14:0];
              4'hF: r_xop <= 1'b1;
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_misao_core.sv
// Self-checking bench for misao_core: directed programs plus random memory images,
// each byte checked against a nibble-level instruction-set model.
module tb_misao_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_enable_read, mem_enable_write, mem_rw;
  logic [7:0]  mem_data_in, mem_data_out;
  logic [14:0] mem_addr;
  logic [15:0] test_data;
  logic        test_carry;

  logic [7:0]  dutMem [0:32767];
  logic [7:0]  refMem [0:32767];

  int checks = 0;
  int errors = 0;
  int unsigned cycleCount = 0;
  int unsigned lastFetchCycle;
  bit gapValid;
  int expGap;

  typedef struct packed {
    logic        wr;
    logic [14:0] addr;
    logic [7:0]  data;
  } memOp_t;
  memOp_t expOps[$];

  logic [14:0] refPc;
  logic [15:0] refAcc, refRs0, refRs1, refRa0, refRa1;
  logic [7:0]  refCfg;
  logic        refC, refXop, refOpCfg, refOpWide;
  int          refOpLeft, refOpIdx;

  misao_core dut (
    .clk              (clk),
    .rst              (rst),
    .mem_enable_read  (mem_enable_read),
    .mem_enable_write (mem_enable_write),
    .mem_data_in      (mem_data_in),
    .mem_addr         (mem_addr),
    .mem_rw           (mem_rw),
    .mem_data_out     (mem_data_out),
    .test_data        (test_data),
    .test_carry       (test_carry)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycleCount <= cycleCount + 1;
  assign mem_data_in = dutMem[mem_addr];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [3:0] hexNib(input byte c);
    if (c >= "0" && c <= "9") return 4'(c - "0");
    return 4'(c - "A" + 8'd10);
  endfunction

  task automatic refReset();
    refPc = 15'd0; refAcc = 16'd0; refRs0 = 16'd0; refRs1 = 16'd0;
    refRa0 = 16'd0; refRa1 = 16'd0; refCfg = 8'd0; refC = 1'b0;
    refXop = 1'b0; refOpCfg = 1'b0; refOpWide = 1'b0; refOpLeft = 0; refOpIdx = 0;
    expOps.delete();
  endtask

  // Arithmetic on the active width as plain integers; ACC bits above it are kept.
  task automatic refAlu(input logic [3:0] op);
    int mask, a, b, r;
    bit wide;
    wide = refCfg[1];
    mask = wide ? 32'hFFFF : 32'hF;
    a = int'(refAcc) & mask;
    b = int'(refRs0) & mask;
    r = a;
    case (op)
      4'h4: begin r = a + b; refC = (r > mask); end
      4'h5: begin r = a - b; refC = (a < b); end
      4'h9: begin r = a + 1; refC = (r > mask); end
`ifdef MISAO_LOGIC_EN
      4'h6: r = a & b;
      4'h7: r = a | b;
      4'h8: r = a ^ b;
      4'hA: r = ~a;
`endif
      default: ;
    endcase
    if (wide) refAcc = 16'(r & mask);
    else      refAcc[3:0] = 4'(r & mask);
  endtask

  task automatic refNibble(input logic [3:0] n, output bit jumped);
    logic [15:0] t;
    jumped = 1'b0;
    if (refOpLeft > 0) begin
      if (refOpCfg)       refCfg[refOpIdx*4 +: 4] = n;
      else if (refOpWide) refAcc[refOpIdx*4 +: 4] = n;
      else                refAcc[3:0] = n;
      refOpIdx++;
      refOpLeft--;
    end else if (refXop) begin
      refXop = 1'b0;
      case (n)
        4'h0: begin refOpCfg = 1'b1; refOpLeft = 2; refOpIdx = 0; end
        4'h1: begin t = refAcc; refAcc = refRa0; refRa0 = t; end
        4'h2: begin t = refRa0; refRa0 = refRa1; refRa1 = t; end
        4'h3: refRs0 = refRs0 >> 1;
        4'h4: refC = 1'b0;
        4'h5: refC = 1'b1;
        default: ;
      endcase
    end else begin
      case (n)
        4'h1: begin
          refOpCfg = 1'b0; refOpWide = refCfg[1];
          refOpLeft = refCfg[1] ? 4 : 1; refOpIdx = 0;
        end
        4'h2: begin t = refAcc; refAcc = refRs0; refRs0 = t; end
        4'h3: begin t = refRs0; refRs0 = refRs1; refRs1 = t; end
        4'h4, 4'h5, 4'h9, 4'h6, 4'h7, 4'h8, 4'hA: refAlu(n);
        4'hB: begin
          expOps.push_back({1'b0, refRa0[14:0], refMem[refRa0[14:0]]});
          refAcc[7:0] = refMem[refRa0[14:0]];
        end
        4'hC: begin
          expOps.push_back({1'b1, refRa0[14:0], refAcc[7:0]});
          refMem[refRa0[14:0]] = refAcc[7:0];
        end
        4'hD: begin jumped = 1'b1; refPc = refRa0[14:0]; end
        4'hF: refXop = 1'b1;
        default: ;
      endcase
    end
  endtask

  task automatic refExecByte();
    logic [7:0] b;
    bit jumpedLow, jumpedHigh;
    b = refMem[refPc];
    refPc = refPc + 15'd1;
    refNibble(b[3:0], jumpedLow);
    if (!jumpedLow) refNibble(b[7:4], jumpedHigh);
    expGap = (jumpedLow ? 2 : 3) + expOps.size();
  endtask

  task automatic waitStrobe(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (mem_enable_read === 1'b1 || mem_enable_write === 1'b1) seen = 1'b1;
    end
    if (seen && mem_enable_write === 1'b1) dutMem[mem_addr] = mem_data_out;
    checks++;
    assert (seen) else begin
      errors++;
      $error("[TB] FAIL strobe-timeout: observed none, expected a strobe within 8 cycles");
    end
  endtask

  task automatic syncFetch();
    bit seen;
    waitStrobe(seen);
    if (seen) begin
      checkOutput("fetch-strobe", 32'({mem_enable_read, mem_enable_write, mem_rw}), 32'(3'b100));
      checkOutput("fetch-addr", 32'(mem_addr), 32'(refPc));
    end
    checkOutput("acc", 32'(test_data), 32'(refAcc));
    checkOutput("carry", 32'(test_carry), 32'(refC));
    if (gapValid) checkOutput("byte-cycles", cycleCount - lastFetchCycle, 32'(expGap));
    lastFetchCycle = cycleCount;
    gapValid = 1'b1;
  endtask

  task automatic runByte();
    memOp_t op;
    bit seen;
    refExecByte();
    while (expOps.size() > 0) begin
      op = expOps.pop_front();
      waitStrobe(seen);
      if (seen) begin
        checkOutput("mem-strobe", 32'({mem_enable_read, mem_enable_write, mem_rw}),
                    op.wr ? 32'(3'b011) : 32'(3'b100));
        checkOutput("mem-addr", 32'(mem_addr), 32'(op.addr));
        if (op.wr) checkOutput("mem-wdata", 32'(mem_data_out), 32'(op.data));
      end
    end
  endtask

  task automatic applyStimulus(input int nBytes);
    for (int i = 0; i < nBytes; i++) begin
      runByte();
      syncFetch();
    end
  endtask

  // Asserts reset after an arbitrary delay, loads a program (hex nibbles in
  // execution order) over zero or random fill, releases reset and syncs to the first fetch.
  task automatic doReset(input string prog, input bit randomFill, input int delay);
    logic [7:0] v;
    logic [3:0] lo, hi;
    repeat (delay) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("reset-acc", 32'(test_data), 32'h0);
    checkOutput("reset-carry", 32'(test_carry), 32'h0);
    checkOutput("reset-strobes", 32'({mem_enable_read, mem_enable_write, mem_rw}), 32'h0);
    for (int a = 0; a < 32768; a++) begin
      v = randomFill ? 8'($urandom) : 8'h00;
      refMem[15'(a)] = v;
      dutMem[15'(a)] = v;
    end
    for (int i = 0; i < prog.len(); i += 2) begin
      lo = hexNib(prog[i]);
      hi = (i + 1 < prog.len()) ? hexNib(prog[i+1]) : 4'h0;
      refMem[15'(i/2)] = {hi, lo};
      dutMem[15'(i/2)] = {hi, lo};
    end
    refReset();
    gapValid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    syncFetch();
  endtask

  initial begin
    doReset("F0E41AAAA0F0C41102120202", 1'b0, 0);
    applyStimulus(5);
    checkOutput("lk16-ldi", 32'(test_data), 32'hAAAA);
    applyStimulus(6);
    checkOutput("ul-ldi-ss", 32'(test_data), 32'hAAA1);
    applyStimulus(1);
    checkOutput("ul-rs0", 32'(test_data), 32'h0002);

    doReset("F0E411111F1F212222F1F2F1", 1'b0, 1);
    applyStimulus(12);
    checkOutput("sa-rsa", 32'(test_data), 32'h1111);

    doReset("F0E41BBBB231CCCC232", 1'b0, 2);
    applyStimulus(10);
    checkOutput("ss-rss", 32'(test_data), 32'hBBBB);

    doReset("11217F32", 1'b0, 1);
    applyStimulus(4);
    checkOutput("rrs", 32'(test_data), 32'h0000);

    doReset("1121F4", 1'b0, 0);
    applyStimulus(3);
    checkOutput("ul-add-acc", 32'(test_data), 32'h0000);
    checkOutput("ul-add-carry", 32'(test_carry), 32'h1);

    doReset("F0E41FFFF9", 1'b0, 2);
    applyStimulus(5);
    checkOutput("lk16-inc-acc", 32'(test_data), 32'h0000);
    checkOutput("lk16-inc-carry", 32'(test_carry), 32'h1);

    doReset("F0E410100F11A500C10000B", 1'b0, 1);
    applyStimulus(12);
    checkOutput("st-ld-acc", 32'(test_data), 32'h005A);
    checkOutput("st-mem", 32'(dutMem[15'h0010]), 32'h5A);

    for (int r = 0; r < 6; r++) begin
      doReset("", 1'b1, int'($urandom_range(0, 2)));
      applyStimulus(200);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
